// File: rtl/div_seq.sv
// div_seq: multi-cycle integer divider for DIV/DIVU.
//
// A 32-step restoring shift-subtract loop on operand magnitudes, with the
// signs of quotient and remainder restored when the loop finishes.
// Quotient goes to LO and remainder goes to HI.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high; aborts any operation in flight
//   start     in   request, sampled only while busy=0
//   A, B      in   dividend, divisor (WIDTH bits)
//   Sign      in   1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
//   busy      out  operation in progress
//   done      out  one-cycle pulse; Q/R/DZ valid in this cycle
//   Q, R      out  quotient and remainder; they hold until the next done
//   DZ        out  divide-by-zero flag for the last operation
//   dbg_state out  current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: start is accepted on any edge where busy=0, which includes the
// DONE cycle, so operations can run back to back. busy stays high from the
// accepting edge until the edge that raises done. start while busy=1 is
// ignored.
//
// Optional feature: define DIV_EARLY_OUT_EN to finish in one step when B=0
// or |A| < |B|. The results are identical with and without the macro.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sign,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DZ,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] STEPS = 6'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] rem;     // partial remainder
    logic [WIDTH-1:0] dvd;     // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] dsr;     // divisor magnitude
    logic [5:0]       cnt;
    logic             qneg;
    logic             rneg;
    logic             dz_r;
    logic             early;   // finish on the next edge without iterating

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign dbg_state = state;

    always_comb begin
        a_mag  = (Sign & A[WIDTH-1]) ? -A : A;
        b_mag  = (Sign & B[WIDTH-1]) ? -B : B;
        rem_sh = {rem[WIDTH-2:0], dvd[WIDTH-1]};
        // The top bit of the 33-bit difference is the borrow.
        trial  = {1'b0, rem_sh} - {1'b0, dsr};
        // On an early exit the loop never ran: the quotient is 0 and the
        // remainder is the untouched dividend magnitude still held in dvd.
        q_mag  = early ? '0  : dvd;
        r_mag  = early ? dvd : rem;
        // With B=0 the remainder already comes out as A. Only the quotient
        // needs forcing, because signed mode would otherwise negate it.
        q_fix  = dz_r ? '1 : (qneg ? -q_mag : q_mag);
        r_fix  = rneg ? -r_mag : r_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Q     <= '0;
            R     <= '0;
            DZ    <= 1'b0;
            rem   <= '0;
            dvd   <= '0;
            dsr   <= '0;
            cnt   <= '0;
            qneg  <= 1'b0;
            rneg  <= 1'b0;
            dz_r  <= 1'b0;
            early <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd   <= a_mag;
                        dsr   <= b_mag;
                        rem   <= '0;
                        cnt   <= '0;
                        qneg  <= Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                        rneg  <= Sign & A[WIDTH-1];
                        dz_r  <= (B == '0);
`ifdef DIV_EARLY_OUT_EN
                        early <= (B == '0) || (a_mag < b_mag);
`else
                        early <= 1'b0;
`endif
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (early || cnt == STEPS) begin
                        Q     <= q_fix;
                        R     <= r_fix;
                        DZ    <= dz_r;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        if (!trial[WIDTH]) begin
                            rem <= trial[WIDTH-1:0];
                            dvd <= {dvd[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= rem_sh;
                            dvd <= {dvd[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + 6'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
